ysyx_22040125_axi_arb: RTL and testbench

YSYX_22040125_AXI_ARB -- requirements
Module: ysyx_22040125_axi_arb

---
 rtl/ysyx_22040125_axi_arb_if.sv | 77 +++++++
 rtl/ysyx_22040125_axi_arb.sv | 115 +++++++++++
 tb/tb_ysyx_22040125_axi_arb.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040125_axi_arb_if.sv
// ysyx_22040125_axi_arb_if: signals between the two CPU masters, the arbiter and the memory slave
interface ysyx_22040125_axi_arb_if #(
    parameter int ID_W = 4
);
    logic            m0_arvalid, m0_arready;
    logic [31:0]     m0_araddr;
    logic [2:0]      m0_arsize;
    logic            m0_rvalid, m0_rready;
    logic [63:0]     m0_rdata;
    logic [1:0]      m0_rresp;
    logic            m1_arvalid, m1_arready;
    logic [31:0]     m1_araddr;
    logic [2:0]      m1_arsize;
    logic            m1_rvalid, m1_rready;
    logic [63:0]     m1_rdata;
    logic [1:0]      m1_rresp;
    logic            m1_awvalid, m1_awready;
    logic [31:0]     m1_awaddr;
    logic [2:0]      m1_awsize;
    logic            m1_wvalid, m1_wready;
    logic [63:0]     m1_wdata;
    logic [7:0]      m1_wstrb;
    logic            m1_bvalid, m1_bready;
    logic [1:0]      m1_bresp;
    logic [ID_W-1:0] s_arid;
    logic [31:0]     s_araddr;
    logic [7:0]      s_arlen;
    logic [2:0]      s_arsize;
    logic [1:0]      s_arburst;
    logic            s_arvalid, s_arready;
    logic [ID_W-1:0] s_rid;
    logic [63:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast, s_rvalid, s_rready;
    logic [ID_W-1:0] s_awid;
    logic [31:0]     s_awaddr;
    logic [7:0]      s_awlen;
    logic [2:0]      s_awsize;
    logic [1:0]      s_awburst;
    logic            s_awvalid, s_awready;
    logic [63:0]     s_wdata;
    logic [7:0]      s_wstrb;
    logic            s_wlast, s_wvalid, s_wready;
    logic [ID_W-1:0] s_bid;
    logic [1:0]      s_bresp;
    logic            s_bvalid, s_bready;

    // arbiter view: master towards the memory slave, responder towards the CPU masters
    modport master (
        input  m0_arvalid, m0_araddr, m0_arsize, m0_rready,
        input  m1_arvalid, m1_araddr, m1_arsize, m1_rready,
        input  m1_awvalid, m1_awaddr, m1_awsize, m1_wvalid, m1_wdata, m1_wstrb, m1_bready,
        input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_awready, s_wready, s_bid, s_bresp, s_bvalid,
        output m0_arready, m0_rvalid, m0_rdata, m0_rresp,
        output m1_arready, m1_rvalid, m1_rdata, m1_rresp,
        output m1_awready, m1_wready, m1_bvalid, m1_bresp,
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        output s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready
    );

    // environment view: CPU masters plus memory slave
    modport slave (
        output m0_arvalid, m0_araddr, m0_arsize, m0_rready,
        output m1_arvalid, m1_araddr, m1_arsize, m1_rready,
        output m1_awvalid, m1_awaddr, m1_awsize, m1_wvalid, m1_wdata, m1_wstrb, m1_bready,
        output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_awready, s_wready, s_bid, s_bresp, s_bvalid,
        input  m0_arready, m0_rvalid, m0_rdata, m0_rresp,
        input  m1_arready, m1_rvalid, m1_rdata, m1_rresp,
        input  m1_awready, m1_wready, m1_bvalid, m1_bresp,
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
        input  s_wdata, s_wstrb, s_wlast, s_wvalid, s_bready
    );
endinterface

// File: rtl/ysyx_22040125_axi_arb.sv
// ysyx_22040125_axi_arb: two CPU masters onto one AXI slave, one transaction outstanding
module ysyx_22040125_axi_arb #(
    parameter int RR_EN = 1,
    parameter int ID_W  = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    ysyx_22040125_axi_arb_if.master bus,
    output logic                   err_id
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_D = 3'd2;
    localparam logic [2:0] WR_A = 3'd3;
    localparam logic [2:0] WR_D = 3'd4;
    localparam logic [2:0] WR_B = 3'd5;

    logic [2:0] state, state_nxt;
    logic       gnt, last_gnt, pick, rd_req;
    logic       st_idle, st_rda, st_rdd, st_wra, st_wrd, st_wrb;
    logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic       unused_ok;

    assign st_idle = state == IDLE;
    assign st_rda  = state == RD_A;
    assign st_rdd  = state == RD_D;
    assign st_wra  = state == WR_A;
    assign st_wrd  = state == WR_D;
    assign st_wrb  = state == WR_B;

    // last_gnt=1 means M1 was served last, so a tie goes to M0
    assign rd_req = bus.m0_arvalid | bus.m1_arvalid;
    assign pick   = (bus.m0_arvalid & bus.m1_arvalid) ? ((RR_EN != 0) ? ~last_gnt : 1'b1) : bus.m1_arvalid;

    assign bus.s_arvalid  = st_rda & (gnt ? bus.m1_arvalid : bus.m0_arvalid);
    assign bus.s_araddr   = gnt ? bus.m1_araddr : bus.m0_araddr;
    assign bus.s_arsize   = gnt ? bus.m1_arsize : bus.m0_arsize;
    assign bus.s_arlen    = 8'd0;
    assign bus.s_arburst  = 2'b01;
    assign bus.s_arid     = ID_W'(gnt);
    assign bus.m0_arready = st_rda & ~gnt & bus.s_arready;
    assign bus.m1_arready = st_rda & gnt & bus.s_arready;

    assign bus.m0_rvalid = st_rdd & ~gnt & bus.s_rvalid;
    assign bus.m1_rvalid = st_rdd & gnt & bus.s_rvalid;
    assign bus.s_rready  = st_rdd & (gnt ? bus.m1_rready : bus.m0_rready);
    assign bus.m0_rdata  = bus.s_rdata;
    assign bus.m1_rdata  = bus.s_rdata;
    assign bus.m0_rresp  = bus.s_rresp;
    assign bus.m1_rresp  = bus.s_rresp;

    assign bus.s_awvalid  = st_wra & bus.m1_awvalid;
    assign bus.m1_awready = st_wra & bus.s_awready;
    assign bus.s_awaddr   = bus.m1_awaddr;
    assign bus.s_awsize   = bus.m1_awsize;
    assign bus.s_awlen    = 8'd0;
    assign bus.s_awburst  = 2'b01;
    assign bus.s_awid     = ID_W'(1);

    assign bus.s_wvalid  = st_wrd & bus.m1_wvalid;
    assign bus.m1_wready = st_wrd & bus.s_wready;
    assign bus.s_wdata   = bus.m1_wdata;
    assign bus.s_wstrb   = bus.m1_wstrb;
    assign bus.s_wlast   = 1'b1;

    assign bus.m1_bvalid = st_wrb & bus.s_bvalid;
    assign bus.s_bready  = st_wrb & bus.m1_bready;
    assign bus.m1_bresp  = bus.s_bresp;

    assign ar_hs = bus.s_arvalid & bus.s_arready;
    assign r_hs  = bus.s_rvalid & bus.s_rready;
    assign aw_hs = bus.s_awvalid & bus.s_awready;
    assign w_hs  = bus.s_wvalid & bus.s_wready;
    assign b_hs  = bus.m1_bvalid & bus.m1_bready;

    // single-beat transfers never look at bid or rlast
    assign unused_ok = ^{bus.s_bid, bus.s_rlast};

    // transaction sequencing; reads beat writes when both wait in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = rd_req ? RD_A : bus.m1_awvalid ? WR_A : IDLE;
            RD_A:    state_nxt = ar_hs ? RD_D : RD_A;
            RD_D:    state_nxt = r_hs ? IDLE : RD_D;
            WR_A:    state_nxt = aw_hs ? WR_D : WR_A;
            WR_D:    state_nxt = w_hs ? WR_B : WR_D;
            WR_B:    state_nxt = b_hs ? IDLE : WR_B;
            default: state_nxt = IDLE;
        endcase
    end

    // state, grant latched on IDLE exit, last read grant updated on read completion
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (st_idle && (rd_req || bus.m1_awvalid))
                gnt <= rd_req ? pick : 1'b1;
            if (r_hs)
                last_gnt <= gnt;
        end
    end

    // sticky flag for a read beat whose id does not match the grant
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            err_id <= 1'b0;
        else if (st_rdd && bus.s_rvalid && bus.s_rid != ID_W'(gnt))
            err_id <= 1'b1;
    end
endmodule

// File: tb/tb_ysyx_22040125_axi_arb.sv
// tb_ysyx_22040125_axi_arb: directed checks of the AXI arbiter (round-robin and fixed-priority)
module tb_ysyx_22040125_axi_arb;
    logic aclk = 1'b0;
    logic aresetn;
    logic err_id, err_id2;
    int   n_chk = 0;
    int   n_err = 0;

    ysyx_22040125_axi_arb_if #(.ID_W(4)) bus ();
    ysyx_22040125_axi_arb_if #(.ID_W(4)) bus2 ();

    ysyx_22040125_axi_arb #(.RR_EN(1), .ID_W(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus), .err_id(err_id)
    );
    ysyx_22040125_axi_arb #(.RR_EN(0), .ID_W(4)) dut2 (
        .aclk(aclk), .aresetn(aresetn), .bus(bus2), .err_id(err_id2)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clr();
        bus.m0_arvalid = 0; bus.m0_araddr = 0; bus.m0_arsize = 0; bus.m0_rready = 0;
        bus.m1_arvalid = 0; bus.m1_araddr = 0; bus.m1_arsize = 0; bus.m1_rready = 0;
        bus.m1_awvalid = 0; bus.m1_awaddr = 0; bus.m1_awsize = 0;
        bus.m1_wvalid = 0; bus.m1_wdata = 0; bus.m1_wstrb = 0; bus.m1_bready = 0;
        bus.s_arready = 0; bus.s_rid = 0; bus.s_rdata = 0; bus.s_rresp = 0; bus.s_rlast = 0;
        bus.s_rvalid = 0; bus.s_awready = 0; bus.s_wready = 0;
        bus.s_bid = 0; bus.s_bresp = 0; bus.s_bvalid = 0;
    endtask

    task automatic do_reset();
        aresetn = 0;
        #1;
        check("rst_state", dut.state, 0);
        check("rst_gnt", dut.gnt, 0);
        check("rst_last", dut.last_gnt, 1);
        check("rst_err", err_id, 0);
        step();
        clr();
        aresetn = 1;
    endtask

    // fixed-priority instance: both masters always requesting, slave always ready
    initial begin
        bus2.m0_arvalid = 1; bus2.m0_araddr = 32'h100; bus2.m0_arsize = 3; bus2.m0_rready = 1;
        bus2.m1_arvalid = 1; bus2.m1_araddr = 32'h200; bus2.m1_arsize = 3; bus2.m1_rready = 1;
        bus2.m1_awvalid = 0; bus2.m1_awaddr = 0; bus2.m1_awsize = 0;
        bus2.m1_wvalid = 0; bus2.m1_wdata = 0; bus2.m1_wstrb = 0; bus2.m1_bready = 0;
        bus2.s_arready = 1; bus2.s_rid = 1; bus2.s_rdata = 64'h55; bus2.s_rresp = 0; bus2.s_rlast = 1;
        bus2.s_rvalid = 1; bus2.s_awready = 0; bus2.s_wready = 0;
        bus2.s_bid = 0; bus2.s_bresp = 0; bus2.s_bvalid = 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int grants;
        clr();
        aresetn = 0;
        bus.m0_arvalid = 1;
        repeat (2) step();
        check("rst_state", dut.state, 0);
        check("rst_s_arvalid", bus.s_arvalid, 0);
        check("rst_m0_arready", bus.m0_arready, 0);
        check("rst_err", err_id, 0);

        // single M0 read, minimum latency
        aresetn = 1;
        bus.m0_araddr = 32'h8000_0000; bus.m0_arsize = 3; bus.m0_arvalid = 1; bus.m0_rready = 1;
        bus.s_arready = 1;
        #1;
        check("idle_s_arvalid", bus.s_arvalid, 0);
        step();
        check("rd0_state", dut.state, 1);
        check("rd0_s_arvalid", bus.s_arvalid, 1);
        check("rd0_s_araddr", bus.s_araddr, 32'h8000_0000);
        check("rd0_s_arsize", bus.s_arsize, 3);
        check("rd0_s_arid", bus.s_arid, 0);
        check("rd0_s_arlen", bus.s_arlen, 0);
        check("rd0_s_arburst", bus.s_arburst, 1);
        check("rd0_m0_arready", bus.m0_arready, 1);
        check("rd0_m1_arready", bus.m1_arready, 0);
        step();
        bus.m0_arvalid = 0; bus.s_arready = 0;
        bus.s_rvalid = 1; bus.s_rdata = 64'h1122334455667788; bus.s_rid = 0;
        #1;
        check("rd0d_state", dut.state, 2);
        check("rd0d_m0_rvalid", bus.m0_rvalid, 1);
        check("rd0d_m0_rdata", bus.m0_rdata, 64'h1122334455667788);
        check("rd0d_m1_rvalid", bus.m1_rvalid, 0);
        check("rd0d_s_rready", bus.s_rready, 1);
        step();
        bus.s_rvalid = 0;
        #1;
        check("rd0_done_state", dut.state, 0);
        check("rd0_done_m0_rvalid", bus.m0_rvalid, 0);

        // M1 drops arvalid in RD_A, then a mismatched rid
        bus.m1_arvalid = 1; bus.m1_araddr = 32'h8000_0040; bus.m1_arsize = 2; bus.m1_rready = 1;
        step();
        bus.m1_arvalid = 0;
        step();
        step();
        check("drop_state", dut.state, 1);
        check("drop_s_arvalid", bus.s_arvalid, 0);
        check("drop_m1_arready", bus.m1_arready, 0);
        bus.m1_arvalid = 1; bus.s_arready = 1;
        step();
        check("drop_rdd_state", dut.state, 2);
        bus.m1_arvalid = 0; bus.s_arready = 0;
        bus.s_rvalid = 1; bus.s_rid = 0; bus.s_rdata = 64'hdead_beef;
        #1;
        check("rid_m1_rvalid", bus.m1_rvalid, 1);
        check("rid_m0_rvalid", bus.m0_rvalid, 0);
        check("rid_m1_rdata", bus.m1_rdata, 64'hdead_beef);
        step();
        bus.s_rvalid = 0;
        check("rid_state", dut.state, 0);
        check("rid_err", err_id, 1);
        step();
        check("rid_err_sticky", err_id, 1);
        do_reset();

        // round-robin tie: M0, M1, M0, M1
        bus.m0_arvalid = 1; bus.m0_araddr = 32'h100; bus.m0_rready = 1;
        bus.m1_arvalid = 1; bus.m1_araddr = 32'h200; bus.m1_rready = 1;
        bus.s_arready = 1; bus.s_rvalid = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_state", dut.state, 1);
            check("rr_s_arid", bus.s_arid, i % 2);
            check("rr_s_araddr", bus.s_araddr, (i % 2) ? 32'h200 : 32'h100);
            bus.s_rid = 4'(i % 2);
            step();
            check("rr_m0_rvalid", bus.m0_rvalid, (i % 2) ? 0 : 1);
            check("rr_m1_rvalid", bus.m1_rvalid, i % 2);
            step();
        end
        bus.m1_arvalid = 0;
        check("rr_err", err_id, 0);

        // read and write requested together: read first, then aw/w/b
        bus.m1_awvalid = 1; bus.m1_awaddr = 32'h8000_0010; bus.m1_awsize = 2;
        bus.m1_wvalid = 1; bus.m1_wdata = 64'hcafe_f00d; bus.m1_wstrb = 8'h0F; bus.m1_bready = 1;
        bus.s_awready = 1; bus.s_wready = 1; bus.s_bvalid = 1; bus.s_bresp = 0; bus.s_bid = 1;
        bus.s_rid = 0;
        step();
        check("rw_rd_state", dut.state, 1);
        check("rw_rd_arid", bus.s_arid, 0);
        check("rw_rd_s_awvalid", bus.s_awvalid, 0);
        check("rw_rd_m1_awready", bus.m1_awready, 0);
        step();
        bus.m0_arvalid = 0;
        #1;
        check("rw_rd_m0_rvalid", bus.m0_rvalid, 1);
        step();
        check("rw_idle_state", dut.state, 0);
        step();
        check("wra_state", dut.state, 3);
        check("wra_s_awvalid", bus.s_awvalid, 1);
        check("wra_s_awaddr", bus.s_awaddr, 32'h8000_0010);
        check("wra_s_awid", bus.s_awid, 1);
        check("wra_s_awlen", bus.s_awlen, 0);
        check("wra_s_awburst", bus.s_awburst, 1);
        check("wra_s_awsize", bus.s_awsize, 2);
        check("wra_m1_awready", bus.m1_awready, 1);
        check("wra_s_arvalid", bus.s_arvalid, 0);
        step();
        check("wrd_state", dut.state, 4);
        check("wrd_s_wvalid", bus.s_wvalid, 1);
        check("wrd_s_wlast", bus.s_wlast, 1);
        check("wrd_s_wstrb", bus.s_wstrb, 8'h0F);
        check("wrd_s_wdata", bus.s_wdata, 64'hcafe_f00d);
        check("wrd_m1_wready", bus.m1_wready, 1);
        check("wrd_s_awvalid", bus.s_awvalid, 0);
        step();
        check("wrb_state", dut.state, 5);
        check("wrb_m1_bvalid", bus.m1_bvalid, 1);
        check("wrb_m1_bresp", bus.m1_bresp, 0);
        check("wrb_s_bready", bus.s_bready, 1);
        check("wrb_s_wvalid", bus.s_wvalid, 0);
        bus.m1_awvalid = 0; bus.m1_wvalid = 0;
        step();
        check("wr_done_state", dut.state, 0);
        check("wr_done_m1_bvalid", bus.m1_bvalid, 0);
        clr();

        // slave holds rvalid while M0 stalls rready
        bus.m0_arvalid = 1; bus.m0_araddr = 32'h300; bus.s_arready = 1;
        step();
        step();
        bus.m0_arvalid = 0; bus.s_arready = 0;
        bus.s_rvalid = 1; bus.s_rdata = 64'h0123_4567_89ab_cdef; bus.s_rid = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_state", dut.state, 2);
            check("stall_s_rready", bus.s_rready, 0);
            check("stall_m0_rdata", bus.m0_rdata, 64'h0123_4567_89ab_cdef);
            step();
        end
        bus.m0_rready = 1;
        #1;
        check("stall_release_s_rready", bus.s_rready, 1);
        step();
        check("stall_done_state", dut.state, 0);
        clr();

        // async reset in WR_D, then a normal M0 read
        bus.m1_awvalid = 1; bus.s_awready = 1; bus.m1_wvalid = 1;
        step();
        step();
        check("wrd_hold_state", dut.state, 4);
        check("wrd_hold_s_wvalid", bus.s_wvalid, 1);
        aresetn = 0;
        #1;
        check("arst_state", dut.state, 0);
        check("arst_s_wvalid", bus.s_wvalid, 0);
        check("arst_m1_wready", bus.m1_wready, 0);
        check("arst_s_awvalid", bus.s_awvalid, 0);
        check("arst_gnt", dut.gnt, 0);
        check("arst_last", dut.last_gnt, 1);
        step();
        check("arst_hold_state", dut.state, 0);
        clr();
        aresetn = 1;
        bus.m0_arvalid = 1; bus.m0_rready = 1; bus.s_arready = 1;
        bus.s_rvalid = 1; bus.s_rdata = 64'haaaa_5555; bus.s_rid = 0;
        step();
        check("post_rst_state", dut.state, 1);
        check("post_rst_arid", bus.s_arid, 0);
        step();
        bus.m0_arvalid = 0;
        #1;
        check("post_rst_m0_rvalid", bus.m0_rvalid, 1);
        check("post_rst_m0_rdata", bus.m0_rdata, 64'haaaa_5555);
        step();
        check("post_rst_done", dut.state, 0);
        clr();

        // fixed priority: M1 always wins, M0 starved
        grants = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus2.s_arvalid) begin
                grants++;
                check("fp_s_arid", bus2.s_arid, 1);
            end
            check("fp_m0_starved", {bus2.m0_arready, bus2.m0_rvalid}, 0);
            step();
        end
        check("fp_grants", grants, 4);
        check("fp_err", err_id2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
